reset_sequencer: RTL and testbench
==================================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter MMCM_RST_CYCLES, default 4: cycles MMCM_RESET is held per attempt; legal range >=1.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent in WAIT_LOCK before retry; legal range >=1.
REQ-003 Parameter LOCK_STABLE_CYCLES, default 256: consecutive synchronized-lock cycles required; legal range >=1.
REQ-004 Parameter HOLD_CYCLES, default 16: extra CORE_RESET cycles after lock is stable; legal range >=1.
REQ-005 CLK  in  1  free-running board clock; the block never runs from the MMCM output.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 LOCKED  in  1  MMCM lock flag; asynchronous to CLK.
REQ-008 MMCM_RESET  out  1  drives the MMCM reset input.
REQ-009 CORE_RESET  out  1  active-high reset for downstream logic.
REQ-010 READY  out  1  high only while the sequencer is in RUN.
REQ-011 LOSS_COUNT  out  8  count of lock losses seen in RUN; saturates at 255.
REQ-012 RETRY_COUNT  out  8  count of WAIT_LOCK timeouts; saturates at 255.

Function
REQ-013 LOCKED shall pass through a two-flop synchronizer, giving lock_s with 2-cycle latency; the FSM uses only lock_s.
REQ-014 The FSM shall be Moore: MMCM_RESET=(state==MMCM_RST), CORE_RESET=(state!=RUN), READY=(state==RUN).
REQ-015 States: MMCM_RST, WAIT_LOCK, STABLE, HOLD, RUN. One shared cycle counter, cleared on every state entry.
REQ-016 MMCM_RST: stay exactly MMCM_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-017 WAIT_LOCK: if lock_s=1, go to STABLE next cycle. Otherwise, after TIMEOUT_CYCLES cycles, go to MMCM_RST and increment RETRY_COUNT with saturation.
REQ-018 STABLE: after LOCK_STABLE_CYCLES cycles with lock_s=1 throughout, go to HOLD. If lock_s=0 in any cycle, go to WAIT_LOCK with the timeout restarted.
REQ-019 HOLD: after HOLD_CYCLES cycles, go to RUN. If lock_s=0 in any cycle, go to WAIT_LOCK.
REQ-020 RUN: if lock_s=0, go to MMCM_RST next cycle and increment LOSS_COUNT with saturation. Otherwise stay in RUN.
REQ-021 Counter width shall be clog2 of the largest of the four parameters plus 1; the counter never wraps.
REQ-022 Both status counters shall hold at 255; no wrap to 0.
REQ-023 RESET shall take priority over every transition and counter update in the same cycle.

Reset
REQ-024 While RESET=1: state=MMCM_RST, counter=0, synchronizer flops=0, LOSS_COUNT=0, RETRY_COUNT=0; therefore MMCM_RESET=1, CORE_RESET=1, READY=0.
REQ-025 RESET asserted mid-sequence, including in RUN, shall restart from MMCM_RST on the first cycle after release; the counter gets a full MMCM_RST_CYCLES.
REQ-026 All flops reset synchronously; no asynchronous reset is used anywhere.

Structure
REQ-027 Shared package reset_seq_pkg shall hold the state enum and the counter-width function.
REQ-028 The two-flop synchronizer shall be the single sub-module, sync_2ff; it carries ASYNC_REG attributes on both flops.
REQ-029 All outputs shall be registered or decoded directly from the state register; no combinational path from LOCKED to any output.

Verification (MMCM_RST_CYCLES=4, TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4; cycle 0 = first cycle after RESET falls)
REQ-030 LOCKED held high -> MMCM_RESET=1 in cycles 0-3; CORE_RESET=1 until cycle 16; READY=1 from cycle 17.
REQ-031 LOCKED held low -> MMCM_RESET pulses 4 cycles every 37 cycles; RETRY_COUNT increments by 1 per pulse; READY stays 0.
REQ-032 LOCKED drops for 1 cycle during STABLE -> return to WAIT_LOCK; READY is delayed by at least 8+4 cycles from re-lock; LOSS_COUNT unchanged.
REQ-033 LOCKED drops in RUN -> READY=0 and MMCM_RESET=1 at 3 cycles after the drop (2 sync + 1); LOSS_COUNT=1.
REQ-034 300 lock losses in RUN -> LOSS_COUNT=255, no wrap; RESET pulse -> all counters 0.
REQ-035 RESET asserted in HOLD, and RESET asserted in the same cycle as a lock drop in RUN -> next state MMCM_RST; LOSS_COUNT not incremented.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding, counter sizing
// and a saturating increment used by the status counters.
package reset_seq_pkg;

  // State encoding kept as plain constants so legacy netlists and probes
  // that match on raw codes keep working.
  typedef logic [2:0] state_t;

  localparam state_t ST_MMCM_RST  = 3'd0;
  localparam state_t ST_WAIT_LOCK = 3'd1;
  localparam state_t ST_STABLE    = 3'd2;
  localparam state_t ST_HOLD      = 3'd3;
  localparam state_t ST_RUN       = 3'd4;

  localparam int STATUS_W = 8;

  // Width of the shared cycle counter: one bit more than clog2 of the
  // longest interval, so the counter can hold the full timeout value.
  function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                   input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STATUS_W-1:0] sat_inc8(input logic [STATUS_W-1:0] v);
    return (v == {STATUS_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_reg;
  (* ASYNC_REG = "TRUE" *) logic sync_reg;

  // Shift the asynchronous input through two back-to-back flops.
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/reset_sequencer.sv
// MMCM bring-up sequencer: pulses the MMCM reset, waits for lock, requires the
// lock to stay stable, holds the core in reset a little longer, then releases
// it. Lock losses and lock timeouts are tallied in saturating counters.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned MMCM_RST_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 1024,
  parameter int unsigned LOCK_STABLE_CYCLES = 256,
  parameter int unsigned HOLD_CYCLES        = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOCKED,
  output logic       MMCM_RESET,
  output logic       CORE_RESET,
  output logic       READY,
  output logic [7:0] LOSS_COUNT,
  output logic [7:0] RETRY_COUNT
);

  localparam int CW = cnt_width(MMCM_RST_CYCLES, TIMEOUT_CYCLES,
                                LOCK_STABLE_CYCLES, HOLD_CYCLES);

  // Terminal counter values. The timed states leave on their last counted
  // cycle; WAIT_LOCK gives up only once the counter has reached the full
  // timeout, i.e. one decision cycle after the timeout window has elapsed.
  localparam logic [CW-1:0] MRC_LAST  = CW'(MMCM_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LSC_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [7:0]    loss_reg, loss_next;
  logic [7:0]    retry_reg, retry_next;
  logic          lock_s;

  sync_2ff u_lock_sync (
    .clk  (CLK),
    .srst (RESET),
    .d    (LOCKED),
    .q    (lock_s)
  );

  // Next-state, shared-counter and status-counter logic; the counter is
  // cleared on every state change and parked at zero in RUN.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + 1'b1;
    loss_next  = loss_reg;
    retry_next = retry_reg;
    case (state_reg)
      ST_MMCM_RST: begin
        if (cnt_reg == MRC_LAST) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt_reg == TO_LAST) begin
          state_next = ST_MMCM_RST;
          cnt_next   = '0;
          retry_next = sat_inc8(retry_reg);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == LSC_LAST) begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_next = ST_WAIT_LOCK;
          cnt_next   = '0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = ST_RUN;
          cnt_next   = '0;
        end
      end
      ST_RUN: begin
        cnt_next = '0;
        if (!lock_s) begin
          state_next = ST_MMCM_RST;
          loss_next  = sat_inc8(loss_reg);
        end
      end
      default: begin
        state_next = ST_MMCM_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and status registers; RESET overrides every update.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= ST_MMCM_RST;
      cnt_reg   <= '0;
      loss_reg  <= '0;
      retry_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      loss_reg  <= loss_next;
      retry_reg <= retry_next;
    end
  end

  // Outputs decode straight from the state register; no path from LOCKED.
  assign MMCM_RESET  = (state_reg == ST_MMCM_RST);
  assign CORE_RESET  = (state_reg != ST_RUN);
  assign READY       = (state_reg == ST_RUN);
  assign LOSS_COUNT  = loss_reg;
  assign RETRY_COUNT = retry_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a timestamp-based phase model predicts every
// cycle's outputs into a scoreboard queue, a monitor pops and compares, and a
// few directed checks pin down the headline timing numbers.
module tb_reset_sequencer;

  localparam int MRC = 4;
  localparam int TO  = 32;
  localparam int LSC = 8;
  localparam int HC  = 4;

  localparam int PH_MMCM   = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_HOLD   = 3;
  localparam int PH_RUN    = 4;

  logic       clk = 1'b0;
  logic       RESET = 1'b1;
  logic       LOCKED = 1'b0;
  logic       MMCM_RESET, CORE_RESET, READY;
  logic [7:0] LOSS_COUNT, RETRY_COUNT;

  typedef struct {
    logic       mmcm;
    logic       core;
    logic       ready;
    logic [7:0] loss;
    logic [7:0] retry;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0;
  int fails = 0;

  // Model: current phase, absolute cycle at which it began, cycle counter,
  // two-deep lock delay line and the status tallies.
  int m_phase = PH_MMCM;
  int m_start = 0;
  int m_now   = 0;
  int m_loss  = 0;
  int m_retry = 0;
  bit m_h0    = 1'b0;
  bit m_h1    = 1'b0;

  reset_sequencer #(
    .MMCM_RST_CYCLES    (MRC),
    .TIMEOUT_CYCLES     (TO),
    .LOCK_STABLE_CYCLES (LSC),
    .HOLD_CYCLES        (HC)
  ) dut (
    .CLK         (clk),
    .RESET       (RESET),
    .LOCKED      (LOCKED),
    .MMCM_RESET  (MMCM_RESET),
    .CORE_RESET  (CORE_RESET),
    .READY       (READY),
    .LOSS_COUNT  (LOSS_COUNT),
    .RETRY_COUNT (RETRY_COUNT)
  );

  initial forever #5 clk = ~clk;

  function automatic int sat255(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  function automatic void enter(input int p);
    m_phase = p;
    m_start = m_now + 1;
  endfunction

  // Advance the model across one clock edge with the given inputs.
  function automatic void model_step(input bit r, input bit l);
    int in_ph;
    bit ls;
    if (r) begin
      enter(PH_MMCM);
      m_loss  = 0;
      m_retry = 0;
      m_h0    = 1'b0;
      m_h1    = 1'b0;
    end else begin
      ls    = m_h1;
      in_ph = m_now - m_start + 1;
      case (m_phase)
        PH_MMCM:   if (in_ph == MRC) enter(PH_WAIT);
        PH_WAIT: begin
          if (ls) enter(PH_STABLE);
          else if (in_ph == TO + 1) begin
            enter(PH_MMCM);
            m_retry = sat255(m_retry);
          end
        end
        PH_STABLE: begin
          if (!ls) enter(PH_WAIT);
          else if (in_ph == LSC) enter(PH_HOLD);
        end
        PH_HOLD: begin
          if (!ls) enter(PH_WAIT);
          else if (in_ph == HC) enter(PH_RUN);
        end
        default: begin
          if (!ls) begin
            enter(PH_MMCM);
            m_loss = sat255(m_loss);
          end
        end
      endcase
      m_h1 = m_h0;
      m_h0 = l;
    end
    m_now++;
  endfunction

  // Drive one cycle of stimulus and queue the predicted post-edge outputs.
  task automatic cycle(input bit r, input bit l);
    exp_t e;
    @(negedge clk);
    RESET  = r;
    LOCKED = l;
    model_step(r, l);
    e.mmcm  = (m_phase == PH_MMCM);
    e.core  = (m_phase != PH_RUN);
    e.ready = (m_phase == PH_RUN);
    e.loss  = 8'(m_loss);
    e.retry = 8'(m_retry);
    e.cyc   = m_now;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic wait_phase(input int p, input int bound, input string name);
    int n;
    n = 0;
    while (m_phase != p && n < bound) begin
      cycle(1'b0, 1'b1);
      n++;
    end
    tests++;
    if (m_phase != p) begin
      fails++;
      $display("FAIL %s: phase %0d not reached within %0d cycles", name, p, bound);
    end
  endtask

  // Monitor: outputs are presented every cycle, so pop one prediction per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        tests++;
        if ({MMCM_RESET, CORE_RESET, READY, LOSS_COUNT, RETRY_COUNT} !==
            {e.mmcm, e.core, e.ready, e.loss, e.retry}) begin
          fails++;
          $display("FAIL sb cyc%0d: got mmcm=%b core=%b ready=%b loss=%0d retry=%0d, expected mmcm=%b core=%b ready=%b loss=%0d retry=%0d",
                   e.cyc, MMCM_RESET, CORE_RESET, READY, LOSS_COUNT, RETRY_COUNT,
                   e.mmcm, e.core, e.ready, e.loss, e.retry);
        end
      end
    end
  end

  initial begin
    int first_ready;
    int rises[$];
    int ready_seen;
    int d;
    bit prev;
    bit lv;
    bit r;
    int left;

    // Lock held high from reset release.
    repeat (3) cycle(1'b1, 1'b1);
    check("reset_mmcm", MMCM_RESET, 1);
    check("reset_ready", READY, 0);
    first_ready = -1;
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b0, 1'b1);
      if (k == 3) check("mmcm_cycle3", MMCM_RESET, 1);
      if (k == 4) check("mmcm_cycle4", MMCM_RESET, 0);
      if (k == 16) check("core_cycle16", CORE_RESET, 1);
      if (READY && first_ready < 0) first_ready = k;
    end
    check("first_ready_cycle", first_ready, 17);
    $display("[TB] lock_high: READY first at cycle %0d", first_ready);

    // Lock never arrives: periodic retries.
    repeat (2) cycle(1'b1, 1'b0);
    prev = 1'b1;
    ready_seen = 0;
    for (int k = 1; k <= 120; k++) begin
      cycle(1'b0, 1'b0);
      if (MMCM_RESET && !prev) rises.push_back(k);
      prev = MMCM_RESET;
      if (READY) ready_seen++;
    end
    check("retry_rises", rises.size(), 3);
    if (rises.size() >= 2) check("retry_period", rises[1] - rises[0], 37);
    check("retry_count", RETRY_COUNT, 3);
    check("no_ready_unlocked", ready_seen, 0);
    $display("[TB] lock_low: %0d MMCM pulses, RETRY_COUNT=%0d", rises.size(), RETRY_COUNT);

    // One-cycle glitch during STABLE.
    repeat (2) cycle(1'b1, 1'b1);
    wait_phase(PH_STABLE, 20, "reach_stable");
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    d = 0;
    while (!READY && d < 60) begin
      cycle(1'b0, 1'b1);
      d++;
    end
    check("relock_delay_ge12", int'(d >= 12 && READY), 1);
    check("stable_glitch_loss", LOSS_COUNT, 0);
    $display("[TB] stable_glitch: READY %0d cycles after re-lock", d);

    // Lock drop in RUN.
    wait_phase(PH_RUN, 40, "reach_run");
    repeat (2) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    check("run_drop_ready_c2", READY, 1);
    cycle(1'b0, 1'b1);
    check("run_drop_ready_c3", READY, 0);
    check("run_drop_mmcm_c3", MMCM_RESET, 1);
    check("run_drop_loss", LOSS_COUNT, 1);
    $display("[TB] run_drop: LOSS_COUNT=%0d", LOSS_COUNT);

    // 300 losses saturate LOSS_COUNT; a reset pulse clears everything.
    repeat (2) cycle(1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      wait_phase(PH_RUN, 60, "loss_loop_run");
      cycle(1'b0, 1'b0);
      repeat (3) cycle(1'b0, 1'b1);
    end
    check("loss_saturated", LOSS_COUNT, 255);
    cycle(1'b1, 1'b1);
    check("loss_cleared", LOSS_COUNT, 0);
    check("retry_cleared", RETRY_COUNT, 0);
    $display("[TB] loss_saturation: 300 drops issued");

    // Reset while in HOLD.
    cycle(1'b0, 1'b1);
    wait_phase(PH_HOLD, 40, "reach_hold");
    cycle(1'b1, 1'b1);
    check("hold_reset_mmcm", MMCM_RESET, 1);
    repeat (3) cycle(1'b0, 1'b1);
    check("hold_reset_still_mmcm", MMCM_RESET, 1);

    // Reset in the same cycle the synchronized lock drop reaches the FSM.
    wait_phase(PH_RUN, 40, "reach_run2");
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b1);
    check("coincident_loss", LOSS_COUNT, 0);
    check("coincident_mmcm", MMCM_RESET, 1);
    $display("[TB] reset_priority: HOLD and RUN-drop cases done");

    // Randomized bursts of lock/unlock with occasional reset pulses.
    left = 0;
    lv   = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      if (left == 0) begin
        lv   = ($urandom_range(0, 99) < 75);
        left = lv ? int'($urandom_range(1, 60)) : int'($urandom_range(1, 12));
      end
      left--;
      r = ($urandom_range(0, 299) == 0);
      cycle(r, lv);
    end
    $display("[TB] random: 2500 cycles, LOSS_COUNT=%0d RETRY_COUNT=%0d", LOSS_COUNT, RETRY_COUNT);

    #20;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
